// File: rtl/signed_adder.sv
// ---------------------------------------------------------------------------
// signed_adder
//
// Adds two two's-complement operands of independent widths. Both operands
// are sign-extended to W = max(IN1_WIDTH, IN2_WIDTH) + 1 bits, so the full
// sum is always exact. The exact sum is then fitted to OUT_WIDTH bits:
//   - OUT_WIDTH >= W : the sum is sign-extended.
//   - OUT_WIDTH <  W : the sum is wrapped to its OUT_WIDTH LSBs. When the
//                      macro SIGNED_ADDER_SATURATE_EN is defined, it is
//                      clamped to the signed OUT_WIDTH range instead.
// The result is registered when REGISTER_OUTPUT == "TRUE". Any other value
// makes the output purely combinational.
//
// Parameters:
//   REGISTER_OUTPUT  "TRUE" selects a registered output (latency 1).
//   IN1_WIDTH        Width of operand a.
//   IN2_WIDTH        Width of operand b.
//   OUT_WIDTH        Width of out.
//
// Ports:
//   clk     in   1          Rising-edge clock for the output register.
//   reset   in   1          Synchronous active-high clear of the output register.
//   enable  in   1          Load enable for the output register.
//   a       in   IN1_WIDTH  Signed operand.
//   b       in   IN2_WIDTH  Signed operand.
//   out     out  OUT_WIDTH  Signed sum.
//
// Build option: define SIGNED_ADDER_SATURATE_EN to saturate instead of wrap.
// ---------------------------------------------------------------------------
module signed_adder #(
    parameter string REGISTER_OUTPUT = "TRUE",
    parameter int    IN1_WIDTH       = 32,
    parameter int    IN2_WIDTH       = 32,
    parameter int    OUT_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [IN1_WIDTH-1:0] a,
    input  logic [IN2_WIDTH-1:0] b,
    output logic [OUT_WIDTH-1:0] out
);

    // One guard bit above the wider operand makes overflow impossible.
    localparam int W      = ((IN1_WIDTH > IN2_WIDTH) ? IN1_WIDTH : IN2_WIDTH) + 1;
    localparam bit IS_REG = (REGISTER_OUTPUT == "TRUE");

    logic [W-1:0]         a_ext;
    logic [W-1:0]         b_ext;
    logic [W-1:0]         sum;
    logic [OUT_WIDTH-1:0] result;

    // W always exceeds each operand width, so the replication count is >= 1.
    assign a_ext = {{(W-IN1_WIDTH){a[IN1_WIDTH-1]}}, a};
    assign b_ext = {{(W-IN2_WIDTH){b[IN2_WIDTH-1]}}, b};
    assign sum   = a_ext + b_ext;

    // -----------------------------------------------------------------------
    // Fit the exact W-bit sum to OUT_WIDTH bits.
    // -----------------------------------------------------------------------
    generate
        if (OUT_WIDTH > W) begin : g_extend
            assign result = {{(OUT_WIDTH-W){sum[W-1]}}, sum};
        end else if (OUT_WIDTH == W) begin : g_exact
            assign result = sum;
        end else begin : g_narrow
`ifdef SIGNED_ADDER_SATURATE_EN
            // Shift-based limits stay legal for OUT_WIDTH == 1, where the
            // range is [-1, 0].
            localparam logic [OUT_WIDTH-1:0] SAT_MIN = OUT_WIDTH'(1) << (OUT_WIDTH - 1);
            localparam logic [OUT_WIDTH-1:0] SAT_MAX = ~SAT_MIN;

            logic [W-OUT_WIDTH:0] upper;
            logic                 fits;

            // The sum fits in OUT_WIDTH bits exactly when every bit from the
            // output sign position upward matches.
            assign upper  = sum[W-1:OUT_WIDTH-1];
            assign fits   = (&upper) | ~(|upper);
            assign result = fits       ? sum[OUT_WIDTH-1:0]
                          : sum[W-1]   ? SAT_MIN
                          :              SAT_MAX;
`else
            logic unused_msbs;

            // Two's-complement wrap: keep the LSBs and drop the rest.
            assign result      = sum[OUT_WIDTH-1:0];
            assign unused_msbs = ^sum[W-1:OUT_WIDTH];
`endif
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Output stage
    // -----------------------------------------------------------------------
    generate
        if (IS_REG) begin : g_reg
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples its pre-edge inputs. Reset is checked before
            // enable so that reset always wins.
            always_ff @(posedge clk) begin
                if (reset) begin
                    out <= '0;
                end else if (enable) begin
                    out <= result;
                end
            end
        end else begin : g_comb
            logic unused_ctrl;

            // In combinational mode, clk, reset and enable are ignored.
            assign out         = result;
            assign unused_ctrl = clk ^ reset ^ enable;
        end
    endgenerate

endmodule

// File: tb/tb_signed_adder.sv
// ---------------------------------------------------------------------------
// tb_signed_adder
//
// Self-checking bench for signed_adder. It instantiates several width and
// mode configurations and first applies directed cases. It then applies
// random operands, with a bias toward range extremes. A reference model
// computes the exact integer sum and then clamps or wraps that sum to the
// output width.
// ---------------------------------------------------------------------------
module tb_signed_adder;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] a32, b32;
    logic [7:0]  a8, b8;
    logic [4:0]  a5;
    logic [2:0]  b3;
    logic [3:0]  a4;
    logic [5:0]  b6;

    logic [31:0] out_reg, out_comb, out_mix;
    logic [7:0]  out_nar;
    logic [3:0]  out_odd;
    logic [11:0] out_wide;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_reg, exp_odd;

    always #5 clk = ~clk;

    // Default build: registered, 32/32 -> 32.
    signed_adder u_reg (
        .clk(clk), .reset(reset), .enable(enable), .a(a32), .b(b32), .out(out_reg)
    );

    signed_adder #(.REGISTER_OUTPUT("FALSE")) u_comb (
        .clk(clk), .reset(reset), .enable(enable), .a(a32), .b(b32), .out(out_comb)
    );

    signed_adder #(.REGISTER_OUTPUT("FALSE"), .IN1_WIDTH(8), .IN2_WIDTH(32), .OUT_WIDTH(32)) u_mix (
        .clk(clk), .reset(reset), .enable(enable), .a(a8), .b(b32), .out(out_mix)
    );

    signed_adder #(.REGISTER_OUTPUT("FALSE"), .IN1_WIDTH(8), .IN2_WIDTH(8), .OUT_WIDTH(8)) u_nar (
        .clk(clk), .reset(reset), .enable(enable), .a(a8), .b(b8), .out(out_nar)
    );

    signed_adder #(.REGISTER_OUTPUT("TRUE"), .IN1_WIDTH(5), .IN2_WIDTH(3), .OUT_WIDTH(4)) u_odd (
        .clk(clk), .reset(reset), .enable(enable), .a(a5), .b(b3), .out(out_odd)
    );

    signed_adder #(.REGISTER_OUTPUT("FALSE"), .IN1_WIDTH(4), .IN2_WIDTH(6), .OUT_WIDTH(12)) u_wide (
        .clk(clk), .reset(reset), .enable(enable), .a(a4), .b(b6), .out(out_wide)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mask(input int w);
        return (64'(1) << w) - 64'(1);
    endfunction

    // Interpret the low w bits of v as a signed integer.
    function automatic longint sx(input logic [31:0] v, input int w);
        longint r;
        r = longint'({32'b0, v} & mask(w));
        if (v[w-1]) r = r - (longint'(1) <<< w);
        return r;
    endfunction

    // Output bit pattern for an exact sum placed into ow bits.
    function automatic logic [63:0] exp_bits(input longint full, input int ow);
        longint r;
        r = full;
`ifdef SIGNED_ADDER_SATURATE_EN
        begin
            longint hi, lo;
            hi = (longint'(1) <<< (ow - 1)) - 1;
            lo = -hi - 1;
            if (r > hi) r = hi;
            if (r < lo) r = lo;
        end
`endif
        return 64'(r) & mask(ow);
    endfunction

    // Random value biased toward the signed min, the signed max and -1.
    function automatic logic [31:0] rv(input int w);
        case ($urandom_range(0, 5))
            0:       return 32'(1) << (w - 1);
            1:       return (32'(1) << (w - 1)) - 32'(1);
            2:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset has priority even with enable high.
        reset = 1'b1; enable = 1'b1;
        a32 = 32'd5; b32 = 32'd7;
        a8 = '0; b8 = '0; a5 = '0; b3 = '0; a4 = '0; b6 = '0;
        #2;
        check("comb_during_reset", 64'(out_comb), 64'd12);
        tick();
        check("reset_out", 64'(out_reg), 64'd0);
        check("reset_odd", 64'(out_odd), 64'd0);

        reset = 1'b0;
        tick();
        check("first_load", 64'(out_reg), 64'd12);

        a32 = 32'hFFFF_FFFD; b32 = 32'd10;
        tick();
        check("signed_add", 64'(out_reg), 64'd7);

        // Hold: input changes while enable is low have no effect.
        enable = 1'b0; a32 = 32'd100; b32 = 32'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold", 64'(out_reg), 64'd7);
        end
        enable = 1'b1;
        tick();
        check("resume", 64'(out_reg), 64'd101);

        // Mixed widths.
        a8 = 8'h80; b32 = 32'd28;
        #1;
        check("mixed_width", 64'(out_mix), 64'hFFFF_FF9C);

        // Narrow output at both overflow directions.
        a8 = 8'd127; b8 = 8'd1;
        #1;
`ifdef SIGNED_ADDER_SATURATE_EN
        check("narrow_pos", 64'(out_nar), 64'h7F);
`else
        check("narrow_pos", 64'(out_nar), 64'h80);
`endif
        a8 = 8'h80; b8 = 8'hFF;
        #1;
`ifdef SIGNED_ADDER_SATURATE_EN
        check("narrow_neg", 64'(out_nar), 64'h80);
`else
        check("narrow_neg", 64'(out_nar), 64'h7F);
`endif

        // Combinational mode ignores reset and enable.
        reset = 1'b1; enable = 1'b0; a32 = 32'd2; b32 = 32'd3;
        #1;
        check("comb_mode", 64'(out_comb), 64'd5);
        @(negedge clk);
        check("comb_mode_negedge", 64'(out_comb), 64'd5);
        tick();
        check("reset_again", 64'(out_reg), 64'd0);
        exp_reg = 64'd0;
        exp_odd = 64'd0;

        // Random phase.
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 19) == 0);
            enable = ($urandom_range(0, 3) != 0);
            a32 = rv(32); b32 = rv(32);
            a8  = 8'(rv(8)); b8 = 8'(rv(8));
            a5  = 5'(rv(5)); b3 = 3'(rv(3));
            a4  = 4'(rv(4)); b6 = 6'(rv(6));
            #1;
            check("rand_comb", 64'(out_comb), exp_bits(sx(a32, 32) + sx(b32, 32), 32));
            check("rand_mix",  64'(out_mix),  exp_bits(sx(32'(a8), 8) + sx(b32, 32), 32));
            check("rand_nar",  64'(out_nar),  exp_bits(sx(32'(a8), 8) + sx(32'(b8), 8), 8));
            check("rand_wide", 64'(out_wide), exp_bits(sx(32'(a4), 4) + sx(32'(b6), 6), 12));
            if (reset) begin
                exp_reg = 64'd0;
                exp_odd = 64'd0;
            end else if (enable) begin
                exp_reg = exp_bits(sx(a32, 32) + sx(b32, 32), 32);
                exp_odd = exp_bits(sx(32'(a5), 5) + sx(32'(b3), 3), 4);
            end
            tick();
            check("rand_reg", 64'(out_reg), exp_reg);
            check("rand_odd", 64'(out_odd), exp_odd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
